// File: rtl/muldiv_issue_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_arbiter_pkg
// Purpose  : Shared FSM encodings, funct3 op codes and default watchdog depth
//            for the M-extension issue arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_issue_arbiter_pkg;

    // Issue FSM: one operation in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // RISC-V M-extension funct3 encodings as seen by the unit.
    localparam logic [2:0] c_F3_MUL    = 3'd0;
    localparam logic [2:0] c_F3_MULH   = 3'd1;
    localparam logic [2:0] c_F3_MULHSU = 3'd2;
    localparam logic [2:0] c_F3_MULHU  = 3'd3;
    localparam logic [2:0] c_F3_DIV    = 3'd4;
    localparam logic [2:0] c_F3_DIVU   = 3'd5;
    localparam logic [2:0] c_F3_REM    = 3'd6;
    localparam logic [2:0] c_F3_REMU   = 3'd7;

    // Must comfortably exceed the unit's worst-case latency (34 cycles).
    localparam int MULDIV_WDOG_DEFAULT = 64;

endpackage
`default_nettype wire

// File: rtl/muldiv_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_arbiter_if
// Purpose  : Requester-side and unit-side signal bundle of the muldiv issue
//            arbiter. "slave" is the arbiter's view, "master" the view of the
//            surrounding requesters plus the shared unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_issue_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [3*NUM_REQ-1:0]  req_funct3;
    logic [32*NUM_REQ-1:0] req_s1;
    logic [32*NUM_REQ-1:0] req_s2;
    logic [NUM_REQ-1:0]    flush;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [31:0]           resp_data;
    logic                  mdu_enable;
    logic [2:0]            mdu_funct3;
    logic [31:0]           mdu_s1;
    logic [31:0]           mdu_s2;
    logic [31:0]           mdu_rd;
    logic                  mdu_is_wait;
    logic                  wdog_err;

    modport master (
        output req_valid, req_funct3, req_s1, req_s2, flush, resp_ready,
               mdu_rd, mdu_is_wait,
        input  req_ready, resp_valid, resp_data, mdu_enable, mdu_funct3,
               mdu_s1, mdu_s2, wdog_err
    );

    modport slave (
        input  req_valid, req_funct3, req_s1, req_s2, flush, resp_ready,
               mdu_rd, mdu_is_wait,
        output req_ready, resp_valid, resp_data, mdu_enable, mdu_funct3,
               mdu_s1, mdu_s2, wdog_err
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_issue_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_arbiter_rr_arbiter
// Purpose  : Round-robin pick: first asserted request at or after the pointer
//            (cyclic). Produces one-hot grant, its index and any_grant.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_issue_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_any_grant
);

    // Pick the valid requester with the smallest cyclic distance from the pointer.
    always_comb begin
        int w_best;
        w_best      = NUM_REQ;
        o_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int w_dist;
            w_dist = (i + NUM_REQ - int'(i_ptr)) % NUM_REQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_grant_idx = PTR_W'(i);
            end
        end
        o_any_grant = (w_best < NUM_REQ);
        o_grant     = o_any_grant ? (NUM_REQ'(1) << o_grant_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_arbiter
// Purpose  : Shares one multi-cycle mul/div unit between NUM_REQ requesters.
//            Round-robin grant, operands latched for the whole operation,
//            result buffered until the owner takes it, watchdog on the unit.
// Options  : MULDIV_RESULT_CACHE_EN - one-entry result cache that lets an exact
//            repeat of the last completed op skip the unit entirely.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_issue_arbiter
    import muldiv_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WDOG_CYCLES = MULDIV_WDOG_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    muldiv_issue_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(WDOG_CYCLES + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [NUM_REQ-1:0] w_arb_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_any_grant;
    logic               w_accept;
    logic               w_done;
    logic               w_expire;
    logic               w_owner_flush;
    logic               w_owner_ack;
    logic               w_kill_now;
    logic               w_cache_hit;
    logic [31:0]        w_cache_result;
    logic [2:0]         w_sel_f3;
    logic [31:0]        w_sel_s1;
    logic [31:0]        w_sel_s2;
    logic [2:0]         r_funct3;
    logic [31:0]        r_s1;
    logic [31:0]        r_s2;
    logic [31:0]        r_result;
    logic               r_kill;
    logic [WD_W-1:0]    r_wdog;
    logic               r_wdog_err;

    // A requester that is flushing its own work must not be granted new work.
    assign w_arb_req = bus.req_valid & ~bus.flush;

    muldiv_issue_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req       (w_arb_req),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_f3 = '0;
        w_sel_s1 = '0;
        w_sel_s2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_f3 = bus.req_funct3[3*i +: 3];
                w_sel_s1 = bus.req_s1[32*i +: 32];
                w_sel_s2 = bus.req_s2[32*i +: 32];
            end
        end
    end

    assign w_owner_oh    = NUM_REQ'(1) << r_owner;
    assign w_owner_flush = |(bus.flush & w_owner_oh);
    assign w_owner_ack   = |(bus.resp_ready & w_owner_oh);
    // A flush seen in this or any earlier EXEC cycle discards the result.
    assign w_kill_now    = r_kill | w_owner_flush;

`ifdef MULDIV_RESULT_CACHE_EN
    logic        r_c_valid;
    logic [2:0]  r_c_funct3;
    logic [31:0] r_c_s1;
    logic [31:0] r_c_s2;
    logic [31:0] r_c_result;

    assign w_cache_hit    = r_c_valid && (r_c_funct3 == w_sel_f3) &&
                            (r_c_s1 == w_sel_s1) && (r_c_s2 == w_sel_s2);
    assign w_cache_result = r_c_result;

    // Remember every result the unit really produced, even a killed one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_c_valid  <= 1'b0;
            r_c_funct3 <= '0;
            r_c_s1     <= '0;
            r_c_s2     <= '0;
            r_c_result <= '0;
        end else if (w_done) begin
            r_c_valid  <= 1'b1;
            r_c_funct3 <= r_funct3;
            r_c_s1     <= r_s1;
            r_c_s2     <= r_s2;
            r_c_result <= bus.mdu_rd;
        end
    end
`else
    assign w_cache_hit    = 1'b0;
    assign w_cache_result = '0;
`endif

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept, completion/watchdog, and result hand-off.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_grant) begin
                    w_accept     = 1'b1;
                    w_state_next = w_cache_hit ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!bus.mdu_is_wait) begin
                    w_done       = 1'b1;
                    w_state_next = w_kill_now ? ST_IDLE : ST_RESP;
                end else if (r_wdog == WD_W'(WDOG_CYCLES - 1)) begin
                    w_expire     = 1'b1;
                    w_state_next = w_kill_now ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_owner_flush || w_owner_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand/owner latch, round-robin pointer, watchdog and result buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_funct3   <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_result   <= '0;
            r_kill     <= 1'b0;
            r_wdog     <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_err <= w_expire;
            if (w_accept) begin
                r_funct3 <= w_sel_f3;
                r_s1     <= w_sel_s1;
                r_s2     <= w_sel_s2;
                r_owner  <= w_grant_idx;
                r_rr_ptr <= (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                 : w_grant_idx + PTR_W'(1);
                r_kill   <= 1'b0;
                r_wdog   <= '0;
                if (w_cache_hit) begin
                    r_result <= w_cache_result;
                end
            end
            if (r_state == ST_EXEC) begin
                r_wdog <= r_wdog + WD_W'(1);
                if (w_owner_flush) begin
                    r_kill <= 1'b1;
                end
            end
            if (w_done) begin
                r_result <= bus.mdu_rd;
            end else if (w_expire) begin
                r_result <= 32'hFFFF_FFFF;
            end
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE) ? w_grant : '0;
    assign bus.mdu_enable = (r_state == ST_EXEC);
    assign bus.mdu_funct3 = r_funct3;
    assign bus.mdu_s1     = r_s1;
    assign bus.mdu_s2     = r_s2;
    assign bus.resp_valid = (r_state == ST_RESP) ? w_owner_oh : '0;
    assign bus.resp_data  = r_result;
    assign bus.wdog_err   = r_wdog_err;

endmodule
`default_nettype wire
